// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Sequences the colour select for the traffic-light decoder.
// The colour order is GREEN -> YELLOW -> RED. Each colour lasts a whole
// number of seconds. A pedestrian request shortens green. When the block
// is disabled, it parks on WHITE.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   en_i       run enable; low returns to IDLE on the next edge
//   ped_req_i  pedestrian request (level or pulse)
//   sel_o      colour code: 00 WHITE, 01 RED, 10 GREEN, 11 YELLOW
//   remain_o   seconds left in the current colour (0 in IDLE)
//   ped_ack_o  one-cycle pulse on the first RED cycle that serves a request
//
// state  | meaning
// IDLE   | disabled, light parked on WHITE, nothing counting
// GREEN  | green phase; may be shortened once by a pedestrian request
// YELLOW | yellow phase; requests are still latched
// RED    | red phase; crossing open, requests ignored
module traffic_light_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_SEC   = 8,
    parameter int YELLOW_SEC  = 2,
    parameter int RED_SEC     = 6,
    parameter int PED_MIN_SEC = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       ped_req_i,
    output logic [1:0] sel_o,
    output logic [3:0] remain_o,
    output logic       ped_ack_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] GREEN_L   = 4'(GREEN_SEC);
    localparam logic [3:0] YELLOW_L  = 4'(YELLOW_SEC);
    localparam logic [3:0] RED_L     = 4'(RED_SEC);
    localparam logic [3:0] PED_MIN_L = 4'(PED_MIN_SEC);

    // The encoding equals the decoder colour code, so sel_o is the state register.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RED    = 2'b01,
        GREEN  = 2'b10,
        YELLOW = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    remain_q, remain_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          tick;
    logic          req_live;

    assign tick     = (presc_q == PRESC_MAX);
    assign req_live = ped_req_i && (state_q == GREEN || state_q == YELLOW);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            remain_q <= 4'd0;
            presc_q  <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;

        if (state_q == IDLE) begin
            presc_d  = '0;
            pend_d   = 1'b0;
            remain_d = 4'd0;
            if (en_i) begin
                state_d  = GREEN;
                remain_d = GREEN_L;
            end
        end else if (!en_i) begin
            state_d  = IDLE;
            remain_d = 4'd0;
            presc_d  = '0;
            pend_d   = 1'b0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (req_live)
                pend_d = 1'b1;

            // Shortening wins over a coincident tick. Once remain sits at
            // PED_MIN_SEC, a held request cannot shorten green a second time.
            if (state_q == GREEN && (pend_q || ped_req_i) && remain_q > PED_MIN_L) begin
                remain_d = PED_MIN_L;
                presc_d  = '0;
            end else if (tick) begin
                if (remain_q > 4'd1) begin
                    remain_d = remain_q - 4'd1;
                end else begin
                    unique case (state_q)
                        GREEN: begin
                            state_d  = YELLOW;
                            remain_d = YELLOW_L;
                        end
                        YELLOW: begin
                            state_d  = RED;
                            remain_d = RED_L;
                            // A request seen on the last yellow cycle is served
                            // here too, so that it is not left pending during RED.
                            if (pend_q || req_live) begin
                                ack_d  = 1'b1;
                                pend_d = 1'b0;
                            end
                        end
                        default: begin
                            state_d  = GREEN;
                            remain_d = GREEN_L;
                        end
                    endcase
                end
            end
        end
    end

    assign sel_o     = state_q;
    assign remain_o  = remain_q;
    assign ped_ack_o = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ped = 1'b0;
    logic [1:0] sel;
    logic [3:0] remain;
    logic       ack;

    int checks   = 0;
    int failures = 0;

    traffic_light_ctrl #(
        .TICK_DIV    (4),
        .GREEN_SEC   (5),
        .YELLOW_SEC  (2),
        .RED_SEC     (3),
        .PED_MIN_SEC (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .ped_req_i (ped),
        .sel_o     (sel),
        .remain_o  (remain),
        .ped_ack_o (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ped;
        int         n;
        logic [1:0] sel;
        logic [3:0] rem;
        logic       ack;
        logic       each;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] sel;
        logic [3:0] rem;
        logic       ack;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic compare(input string name);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (sel !== e.sel || remain !== e.rem || ack !== e.ack) begin
            failures++;
            $display("FAIL %s vec=%0d got sel=%b rem=%0d ack=%b want sel=%b rem=%0d ack=%b",
                     name, e.idx, sel, remain, ack, e.sel, e.rem, e.ack);
        end
    endtask

    initial begin
        int n;
        // {rst, en, ped, cycles, sel, remain, ack, check every cycle}
        vecs.push_back('{1, 0, 0,  3, 2'b00, 4'd0, 0, 0}); // 0 reset held
        vecs.push_back('{0, 0, 0, 20, 2'b00, 4'd0, 0, 1}); // 1 idle while disabled
        vecs.push_back('{0, 1, 0,  1, 2'b10, 4'd5, 0, 0}); // 2 enable latency 1
        vecs.push_back('{0, 1, 0,  3, 2'b10, 4'd5, 0, 0}); // 3 no tick yet
        vecs.push_back('{0, 1, 0,  1, 2'b10, 4'd4, 0, 0}); // 4 first tick
        vecs.push_back('{0, 1, 0, 12, 2'b10, 4'd1, 0, 0}); // 5 last green second
        vecs.push_back('{0, 1, 0,  4, 2'b11, 4'd2, 0, 0}); // 6 yellow after 20
        vecs.push_back('{0, 1, 0,  8, 2'b01, 4'd3, 0, 0}); // 7 red, no ack
        vecs.push_back('{0, 1, 0, 12, 2'b10, 4'd5, 0, 0}); // 8 period 40
        vecs.push_back('{0, 1, 1,  1, 2'b10, 4'd2, 0, 0}); // 9 ped pulse shortens
        vecs.push_back('{0, 1, 0,  7, 2'b10, 4'd1, 0, 0}); // 10
        vecs.push_back('{0, 1, 0,  1, 2'b11, 4'd2, 0, 0}); // 11 yellow 8 after
        vecs.push_back('{0, 1, 0,  7, 2'b11, 4'd1, 0, 0}); // 12
        vecs.push_back('{0, 1, 0,  1, 2'b01, 4'd3, 1, 0}); // 13 ack on red entry
        vecs.push_back('{0, 1, 0,  1, 2'b01, 4'd3, 0, 0}); // 14 ack one cycle
        vecs.push_back('{0, 1, 0, 11, 2'b10, 4'd5, 0, 0}); // 15
        vecs.push_back('{0, 1, 0, 12, 2'b10, 4'd2, 0, 0}); // 16 green remain 2
        vecs.push_back('{0, 1, 1,  4, 2'b10, 4'd1, 0, 0}); // 17 held: no shortening
        vecs.push_back('{0, 1, 1,  4, 2'b11, 4'd2, 0, 0}); // 18
        vecs.push_back('{0, 1, 1,  7, 2'b11, 4'd1, 0, 0}); // 19
        vecs.push_back('{0, 1, 1,  1, 2'b01, 4'd3, 1, 0}); // 20 single ack
        vecs.push_back('{0, 1, 1,  1, 2'b01, 4'd3, 0, 0}); // 21 req in red ignored
        vecs.push_back('{0, 1, 1, 10, 2'b01, 4'd1, 0, 0}); // 22
        vecs.push_back('{0, 1, 0,  1, 2'b10, 4'd5, 0, 0}); // 23 red timing unchanged
        vecs.push_back('{0, 1, 0, 20, 2'b11, 4'd2, 0, 0}); // 24
        vecs.push_back('{0, 1, 1,  1, 2'b11, 4'd2, 0, 0}); // 25 pending in yellow
        vecs.push_back('{0, 0, 0,  1, 2'b00, 4'd0, 0, 0}); // 26 disable latency 1
        vecs.push_back('{0, 0, 0,  3, 2'b00, 4'd0, 0, 1}); // 27
        vecs.push_back('{0, 1, 0,  1, 2'b10, 4'd5, 0, 0}); // 28 re-enable full green
        vecs.push_back('{0, 1, 0, 19, 2'b10, 4'd1, 0, 0}); // 29
        vecs.push_back('{0, 1, 0,  1, 2'b11, 4'd2, 0, 0}); // 30
        vecs.push_back('{0, 1, 0,  8, 2'b01, 4'd3, 0, 0}); // 31 pending discarded
        vecs.push_back('{0, 1, 0,  2, 2'b01, 4'd3, 0, 0}); // 32 mid red
        vecs.push_back('{1, 1, 0,  1, 2'b00, 4'd0, 0, 0}); // 33 reset wins over en
        vecs.push_back('{0, 1, 0,  1, 2'b10, 4'd5, 0, 0}); // 34 like first enable
        vecs.push_back('{0, 1, 0, 20, 2'b11, 4'd2, 0, 0}); // 35
        vecs.push_back('{0, 1, 0, 20, 2'b10, 4'd5, 0, 0}); // 36
        vecs.push_back('{0, 1, 0,  8, 2'b10, 4'd3, 0, 0}); // 37 remain = PED_MIN+1
        vecs.push_back('{0, 1, 1,  1, 2'b10, 4'd2, 0, 0}); // 38 still shortens
        vecs.push_back('{0, 1, 0,  7, 2'b10, 4'd1, 0, 0}); // 39
        vecs.push_back('{0, 1, 0,  1, 2'b11, 4'd2, 0, 0}); // 40
        vecs.push_back('{0, 1, 0,  8, 2'b01, 4'd3, 1, 0}); // 41

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                logic chk;
                rst = vecs[i].rst;
                en  = vecs[i].en;
                ped = vecs[i].ped;
                chk = vecs[i].each || (c == vecs[i].n - 1);
                if (chk)
                    sb.push_back('{i, vecs[i].sel, vecs[i].rem, vecs[i].ack});
                @(posedge clk);
                #1;
                if (chk)
                    compare("vector");
            end
        end

        // RED phase length, measured cycle by cycle with a bound.
        ped = 1'b0;
        n = 0;
        while (sel == 2'b01 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL red_length got=%0d want=12", n);
        end

        // Green phase length, plus acks must stay low throughout.
        n = 0;
        while (sel == 2'b10 && n < 100) begin
            checks++;
            if (ack !== 1'b0) begin
                failures++;
                $display("FAIL green_ack got=%b want=0", ack);
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL green_length got=%0d want=20", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
